// File: rtl/interval_timer_100us.sv
// Programmable interval timer counting in 100 us ticks derived from an
// 11-bit prescaler; supports one-shot and auto-reload modes with sticky irq/overrun.
module interval_timer_100us #(
  parameter int TICKCOUNT = 1249
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [15:0] load_val,
  input  logic        periodic,
  input  logic        cancel,
  input  logic        irq_ack,
  output logic        busy,
  output logic        irq,
  output logic        overrun,
  output logic [15:0] remaining
);

  localparam logic [10:0] TICK_RELOAD = 11'(TICKCOUNT);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [10:0] ticks_q, ticks_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] reload_q, reload_d;
  logic        periodic_q, periodic_d;
  logic        busy_q, busy_d;
  logic        irq_q, irq_d;
  logic        overrun_q, overrun_d;
  logic        expiry;

  // Priority is write > cancel > countdown; a zero-length write counts as an
  // immediate expiry so software sees the same irq it would for a real interval.
  always_comb begin
    state_d     = state_q;
    ticks_d     = ticks_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    expiry      = 1'b0;

    if (write) begin
      periodic_d = periodic;
      reload_d   = load_val;
      if (load_val != 16'd0) begin
        state_d     = RUN;
        remaining_d = load_val;
        ticks_d     = TICK_RELOAD;
      end else begin
        state_d     = IDLE;
        remaining_d = 16'd0;
        expiry      = 1'b1;
      end
    end else if (cancel) begin
      state_d     = IDLE;
      remaining_d = 16'd0;
    end else if (state_q == RUN) begin
      if (ticks_q != 11'd0) begin
        ticks_d = ticks_q - 11'd1;
      end else if (remaining_q > 16'd1) begin
        ticks_d     = TICK_RELOAD;
        remaining_d = remaining_q - 16'd1;
      end else begin
        expiry = 1'b1;
        if (periodic_q) begin
          remaining_d = reload_q;
          ticks_d     = TICK_RELOAD;
        end else begin
          remaining_d = 16'd0;
          state_d     = IDLE;
        end
      end
    end

    busy_d = (state_d == RUN);

    // An expiry always wins over an acknowledge on the same edge; overrun only
    // accumulates when the previous irq was left unacknowledged.
    if (expiry) begin
      irq_d     = 1'b1;
      overrun_d = irq_ack ? 1'b0 : (overrun_q | irq_q);
    end else if (irq_ack) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end else begin
      irq_d     = irq_q;
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ticks_q     <= TICK_RELOAD;
      remaining_q <= 16'd0;
      reload_q    <= 16'd0;
      periodic_q  <= 1'b0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ticks_q     <= ticks_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      busy_q      <= busy_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = busy_q;
  assign irq       = irq_q;
  assign overrun   = overrun_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_interval_timer_100us.sv
// Bench for interval_timer_100us: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a deadline-based model.
module tb_interval_timer_100us;

  localparam int TICKCOUNT = 4;
  localparam int PERIOD    = TICKCOUNT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [15:0] load_val = 16'd0;
  logic        periodic = 1'b0;
  logic        cancel = 1'b0;
  logic        irq_ack = 1'b0;
  logic        busy, irq, overrun;
  logic [15:0] remaining;

  int n_vec = 0;
  int n_err = 0;

  interval_timer_100us #(.TICKCOUNT(TICKCOUNT)) dut (
    .clk(clk), .reset(reset), .write(write), .load_val(load_val),
    .periodic(periodic), .cancel(cancel), .irq_ack(irq_ack),
    .busy(busy), .irq(irq), .overrun(overrun), .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Model tracks the interval as "edges elapsed since start" against a length
  // of N*PERIOD edges; remaining is derived from that by division.
  bit m_valid = 0;
  bit m_run = 0, m_per = 0, m_irq = 0, m_ov = 0;
  int m_n = 0, m_k = 0;

  always @(posedge clk) begin
    bit exp_evt;
    exp_evt = 0;
    if (reset) begin
      m_run = 0; m_irq = 0; m_ov = 0; m_valid = 1;
    end else begin
      if (write) begin
        if (load_val != 16'd0) begin
          m_run = 1; m_n = int'(load_val); m_per = periodic; m_k = 0;
        end else begin
          m_run = 0; exp_evt = 1;
        end
      end else if (cancel) begin
        m_run = 0;
      end else if (m_run) begin
        m_k++;
        if (m_k == m_n * PERIOD) begin
          exp_evt = 1;
          if (m_per) m_k = 0;
          else m_run = 0;
        end
      end
      if (exp_evt) begin
        m_ov  = irq_ack ? 1'b0 : (m_ov | m_irq);
        m_irq = 1;
      end else if (irq_ack) begin
        m_irq = 0; m_ov = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input bit e_busy, input bit e_irq,
                             input bit e_ov, input logic [15:0] e_rem);
    n_vec++;
    if (busy !== e_busy || irq !== e_irq || overrun !== e_ov || remaining !== e_rem) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got busy=%0b irq=%0b overrun=%0b remaining=%0d, expected busy=%0b irq=%0b overrun=%0b remaining=%0d",
               name, $time, busy, irq, overrun, remaining, e_busy, e_irq, e_ov, e_rem);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid)
      checkOutput("model", m_run, m_irq, m_ov,
                  m_run ? 16'(m_n - m_k / PERIOD) : 16'd0);
  end

  // Drives one edge worth of inputs and returns 2 time units after that edge.
  task automatic applyStimulus(input bit rst, input bit w, input logic [15:0] lv,
                               input bit p, input bit c, input bit a);
    reset = rst; write = w; load_val = lv; periodic = p; cancel = c; irq_ack = a;
    @(posedge clk);
    #2;
    reset = 0; write = 0; load_val = 16'd0; periodic = 0; cancel = 0; irq_ack = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(0, 0, 16'd0, 0, 0, 0);
  endtask

  initial begin
    applyStimulus(1, 0, 16'd0, 0, 0, 0);
    applyStimulus(1, 0, 16'd0, 0, 0, 0);
    checkOutput("reset_state", 0, 0, 0, 16'd0);

    // One-shot of 3 ticks: expiry 15 edges after the write edge.
    applyStimulus(0, 1, 16'd3, 0, 0, 0);
    checkOutput("oneshot_start", 1, 0, 0, 16'd3);
    idleCycles(4);  checkOutput("oneshot_e4", 1, 0, 0, 16'd3);
    idleCycles(1);  checkOutput("oneshot_e5", 1, 0, 0, 16'd2);
    idleCycles(5);  checkOutput("oneshot_e10", 1, 0, 0, 16'd1);
    idleCycles(4);  checkOutput("oneshot_e14", 1, 0, 0, 16'd1);
    idleCycles(1);  checkOutput("oneshot_e15", 0, 1, 0, 16'd0);
    applyStimulus(0, 0, 16'd0, 0, 0, 1);
    checkOutput("ack_clears", 0, 0, 0, 16'd0);

    // Periodic 2 ticks without ack: irq at 10, overrun at 20.
    applyStimulus(0, 1, 16'd2, 1, 0, 0);
    idleCycles(9);  checkOutput("periodic_e9", 1, 0, 0, 16'd1);
    idleCycles(1);  checkOutput("periodic_e10", 1, 1, 0, 16'd2);
    idleCycles(9);  checkOutput("periodic_e19", 1, 1, 0, 16'd1);
    idleCycles(1);  checkOutput("periodic_e20", 1, 1, 1, 16'd2);
    idleCycles(9);
    applyStimulus(0, 0, 16'd0, 0, 0, 1);
    checkOutput("ack_same_edge_as_expiry", 1, 1, 0, 16'd2);
    applyStimulus(0, 0, 16'd0, 0, 0, 1);
    checkOutput("ack_after_expiry", 1, 0, 0, 16'd2);
    applyStimulus(0, 0, 16'd0, 0, 1, 0);
    checkOutput("cancel_periodic", 0, 0, 0, 16'd0);

    // Cancel at edge 7 of a 4-tick interval: no irq ever.
    applyStimulus(0, 1, 16'd4, 0, 0, 0);
    idleCycles(6);
    applyStimulus(0, 0, 16'd0, 0, 1, 0);
    checkOutput("cancel_e7", 0, 0, 0, 16'd0);
    idleCycles(30);
    checkOutput("cancel_no_irq", 0, 0, 0, 16'd0);
    applyStimulus(0, 1, 16'd4, 0, 1, 0);
    checkOutput("write_beats_cancel", 1, 0, 0, 16'd4);

    // Zero-length write expires at once; rewrite restarts the deadline.
    applyStimulus(0, 1, 16'd0, 0, 0, 0);
    checkOutput("zero_write", 0, 1, 0, 16'd0);
    applyStimulus(0, 0, 16'd0, 0, 0, 1);
    applyStimulus(0, 1, 16'd3, 0, 0, 0);
    idleCycles(7);
    applyStimulus(0, 1, 16'd5, 0, 0, 0);
    idleCycles(24); checkOutput("rewrite_e24", 1, 0, 0, 16'd1);
    idleCycles(1);  checkOutput("rewrite_e25", 0, 1, 0, 16'd0);
    applyStimulus(0, 0, 16'd0, 0, 0, 1);

    // Maximum interval loads without wrap.
    applyStimulus(0, 1, 16'hFFFF, 1, 0, 0);
    checkOutput("max_load", 1, 0, 0, 16'hFFFF);
    idleCycles(5);  checkOutput("max_load_e5", 1, 0, 0, 16'hFFFE);

    // Reset mid-RUN with irq set.
    applyStimulus(0, 1, 16'd2, 1, 0, 0);
    idleCycles(10); checkOutput("pre_reset", 1, 1, 0, 16'd2);
    applyStimulus(1, 0, 16'd0, 0, 0, 0);
    checkOutput("reset_mid_run", 0, 0, 0, 16'd0);

    for (int i = 0; i < 4000; i++) begin
      bit r_rst, r_w, r_p, r_c, r_a;
      logic [15:0] r_lv;
      r_rst = ($urandom_range(0, 399) == 0);
      r_w   = ($urandom_range(0, 39) == 0);
      r_p   = $urandom_range(0, 1) == 1;
      r_c   = ($urandom_range(0, 59) == 0);
      r_a   = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0:       r_lv = 16'hFFFF;
        1:       r_lv = 16'($urandom);
        default: r_lv = 16'($urandom_range(0, 6));
      endcase
      applyStimulus(r_rst, r_w, r_lv, r_p, r_c, r_a);
    end
    idleCycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
